cpu_step_sequencer: RTL and testbench
=====================================

Name: cpu_step_sequencer

Overview:
- Synthesisable, parametrised stepping controller for the 5-stage Cpu, clocked on the fast clock `clkb`.
- Produces the slow stage strobe (the `clka` waveform: a short high phase within a long period) as a clock-enable.
- Adds start, halt/resume, single-step, bounded run length, a pipeline-occupancy mask and a one-cycle-delayed sample strobe for trace and monitor logic.
- Replaces free-running stimulus clocking and hard-coded stop times with a controllable, countable sequencer.

Parameters:
- PERIOD, 40, `clkb` cycles per CPU step (must be >= 2).
- HIGH, 2, `clkb` cycles `phase_hi` stays asserted at the start of each step (1 <= HIGH < PERIOD).
- STAGES, 5, pipeline depth tracked by `stage_valid`.
- MAX_STEPS, 41, steps executed before automatic DONE; 0 means unbounded.
- CNT_W, 16, width of `step_count`.

Ports:
- clkb  in  1  fast system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin sequencing (ignored outside IDLE).
- mode_step  in  1  sampled when `start` is accepted: 1 = single-step mode, 0 = free run.
- step_req  in  1  in single-step mode, releases exactly one step.
- halt_req  in  1  request a pause at the next step boundary.
- resume  in  1  leave HALT.
- flush  in  1  clear `stage_valid` at the next step boundary (no new instruction inserted at that step).
- cpu_en  out  1  one-cycle pulse at the first cycle of each step (phase 0).
- phase_hi  out  1  high during phases 0..HIGH-1 of an active step.
- sample  out  1  one-cycle pulse, one cycle after `cpu_en`.
- stage_valid  out  STAGES  bit i = stage i holds a valid instruction.
- step_count  out  CNT_W  number of steps issued since reset.
- state  out  3  IDLE=0, RUN=1, WAIT=2, HALT=3, DONE=4.
- done  out  1  high in DONE.

Behaviour:
- Reset values: state=IDLE; phase counter=0; cpu_en=0; phase_hi=0; sample=0; stage_valid=0; step_count=0; done=0.
- Phase counter `ph` (0..PERIOD-1) advances only while a step is active. It wraps PERIOD-1 -> 0, and that cycle is the step boundary.
- Active step: `cpu_en`=1 when ph==0. `phase_hi`=(ph<HIGH). All outputs are registered.
- At each `cpu_en`:
  - `step_count` increments, saturating at all-ones.
  - `stage_valid` shifts: {stage_valid[STAGES-2:0], 1}. Bit 0 is the newest instruction.
- `flush` is latched until the next boundary. At that boundary, `stage_valid` becomes 0 instead of shifting.
- IDLE: on `start`, go to RUN (mode_step=0) or WAIT (mode_step=1). From RUN, the first `cpu_en` occurs on the cycle after `start` is accepted.
- RUN: steps back-to-back with no gap. At a boundary:
  - if MAX_STEPS!=0 and step_count==MAX_STEPS -> DONE;
  - else if `halt_req` was seen during the step -> HALT;
  - else the next step begins immediately.
- WAIT (single-step): `ph` is held at 0 and `phase_hi` is low. On `step_req`, run exactly one full step of PERIOD cycles, then return to WAIT, or go to DONE if the limit is reached. A `step_req` arriving during that step is ignored; no queueing.
- HALT: `ph` is held at 0 with no strobes. `resume` returns to RUN (or to WAIT if single-step mode was latched). `resume` and `halt_req` in the same cycle: resume wins.
- DONE: terminal, no strobes, `done`=1. Only `rst` exits.
- `halt_req` never truncates a step. A step once begun always completes its PERIOD cycles.
- `rst` asserted mid-step: all state returns to reset values on that edge. No partial step is counted.
- `start` outside IDLE, and `step_req` outside WAIT, are ignored.

Test Plan:
- PERIOD=4, HIGH=1, MAX_STEPS=3, start (mode_step=0) -> `cpu_en` pulses at 3 cycles, 4 apart; `sample` one cycle later each; step_count 1,2,3; DONE after 12 active cycles; stage_valid=3'b111 (STAGES=3).
- Defaults, free run for 2 steps -> phase_hi high 2 of every 40 cycles; stage_valid 00001 then 00011.
- Single-step: start (mode_step=1), idle 10 cycles -> no strobes; one step_req -> exactly one cpu_en, step_count=1; a second step_req inside that step is ignored.
- halt_req at ph=10 of step 2 -> step 2 completes, state=HALT, step_count=2; resume -> next cpu_en the following cycle, step_count=3.
- flush during step 4 with stage_valid=01111 -> at the next boundary stage_valid=00000; the following step gives 00001.
- rst at ph=20 of step 3 -> next cycle all outputs 0, state=IDLE; a subsequent start behaves as from power-up.

Source files
------------

// File: rtl/cpu_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module : cpu_step_sequencer
// Brief  : Clock-enable stepping controller (start/halt/single-step/run limit)
// Rev    : 1.0
// ============================================================================
module cpu_step_sequencer #(
    parameter int PERIOD    = 40,
    parameter int HIGH      = 2,
    parameter int STAGES    = 5,
    parameter int MAX_STEPS = 41,
    parameter int CNT_W     = 16
) (
    input  logic              clkb,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_step,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              flush,
    output logic              cpu_en,
    output logic              phase_hi,
    output logic              sample,
    output logic [STAGES-1:0] stage_valid,
    output logic [CNT_W-1:0]  step_count,
    output logic [2:0]        state,
    output logic              done
);

    localparam int                  c_PH_W    = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [c_PH_W-1:0]   c_PH_LAST = c_PH_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]    c_MAX     = CNT_W'(MAX_STEPS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_WAIT = 3'd2,
        S_HALT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_PH_W-1:0]   r_ph;
    logic                r_active;
    logic                r_mode;
    logic                r_halt;
    logic                r_flush;
    logic                r_cpu_en;
    logic                r_phase_hi;
    logic                r_sample;
    logic [STAGES-1:0]   r_stage_valid;
    logic [CNT_W-1:0]    r_step_count;
    logic                r_done;

    logic                w_boundary;
    logic                w_flush_now;
    logic                w_halt_now;
    logic                w_limit;
    logic                w_begin;
    logic [STAGES-1:0]   w_shifted;

    assign w_boundary  = r_active && (r_ph == c_PH_LAST);
    assign w_flush_now = r_flush | flush;
    assign w_halt_now  = r_halt | halt_req;
    assign w_limit     = (MAX_STEPS != 0) && (r_step_count == c_MAX);
    assign w_shifted   = (r_stage_valid << 1) | STAGES'(1);

    // A new step starts on the edge that raises cpu_en, so the strobe is registered.
    assign w_begin = ((r_state == S_IDLE) && start && !mode_step)
                   || ((r_state == S_WAIT) && step_req)
                   || ((r_state == S_HALT) && resume && !r_mode)
                   || (w_boundary && !w_limit && !w_halt_now && !r_mode);

    always_ff @(posedge clkb) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ph          <= '0;
            r_active      <= 1'b0;
            r_mode        <= 1'b0;
            r_halt        <= 1'b0;
            r_flush       <= 1'b0;
            r_cpu_en      <= 1'b0;
            r_phase_hi    <= 1'b0;
            r_sample      <= 1'b0;
            r_stage_valid <= '0;
            r_step_count  <= '0;
            r_done        <= 1'b0;
        end else begin
            r_sample <= r_cpu_en;
            r_cpu_en <= 1'b0;
            r_flush  <= w_boundary ? 1'b0 : (r_flush | flush);
            r_halt   <= w_boundary ? 1'b0 : (r_halt | (r_active & halt_req));
            if ((r_state == S_IDLE) && start) begin
                r_mode <= mode_step;
            end

            if (w_begin) begin
                r_state    <= S_RUN;
                r_active   <= 1'b1;
                r_ph       <= '0;
                r_cpu_en   <= 1'b1;
                r_phase_hi <= 1'b1;
                if (r_step_count != {CNT_W{1'b1}}) begin
                    r_step_count <= r_step_count + 1'b1;
                end
                // A flushed boundary empties the pipe and inserts nothing this step.
                r_stage_valid <= (w_boundary && w_flush_now) ? '0 : w_shifted;
            end else if (w_boundary) begin
                r_active   <= 1'b0;
                r_ph       <= '0;
                r_phase_hi <= 1'b0;
                if (w_flush_now) begin
                    r_stage_valid <= '0;
                end
                if (w_limit) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end else if (w_halt_now) begin
                    r_state <= S_HALT;
                end else begin
                    r_state <= S_WAIT;
                end
            end else if (r_active) begin
                r_ph       <= r_ph + 1'b1;
                r_phase_hi <= ((int'(r_ph) + 1) < HIGH);
            end else if ((r_state == S_IDLE) && start) begin
                r_state <= S_WAIT;
            end else if ((r_state == S_HALT) && resume) begin
                r_state <= S_WAIT;
            end
        end
    end

    assign cpu_en      = r_cpu_en;
    assign phase_hi    = r_phase_hi;
    assign sample      = r_sample;
    assign stage_valid = r_stage_valid;
    assign step_count  = r_step_count;
    assign state       = r_state;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_step_sequencer
// Brief  : Two configurations of the sequencer checked against a step-level model
// Rev    : 1.0
// ============================================================================
module tb_cpu_step_sequencer;

    logic clk;
    logic rst, start, mode_step, step_req, halt_req, resume, flush;

    logic        cpu_en_a, phase_hi_a, sample_a, done_a;
    logic [4:0]  stage_valid_a;
    logic [15:0] step_count_a;
    logic [2:0]  state_a;

    logic        cpu_en_b, phase_hi_b, sample_b, done_b;
    logic [2:0]  stage_valid_b;
    logic [15:0] step_count_b;
    logic [2:0]  state_b;

    int total = 0;
    int bad   = 0;

    cpu_step_sequencer dut_a (
        .clkb(clk), .rst(rst), .start(start), .mode_step(mode_step),
        .step_req(step_req), .halt_req(halt_req), .resume(resume), .flush(flush),
        .cpu_en(cpu_en_a), .phase_hi(phase_hi_a), .sample(sample_a),
        .stage_valid(stage_valid_a), .step_count(step_count_a),
        .state(state_a), .done(done_a)
    );

    cpu_step_sequencer #(.PERIOD(4), .HIGH(1), .STAGES(3), .MAX_STEPS(3), .CNT_W(16)) dut_b (
        .clkb(clk), .rst(rst), .start(start), .mode_step(mode_step),
        .step_req(step_req), .halt_req(halt_req), .resume(resume), .flush(flush),
        .cpu_en(cpu_en_b), .phase_hi(phase_hi_b), .sample(sample_b),
        .stage_valid(stage_valid_b), .step_count(step_count_b),
        .state(state_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int period;
        int high;
        int stages;
        int maxs;
    } cfg_t;

    // Model view: which step we are in and how far through it, not a phase register.
    typedef struct {
        int st;
        bit busy;
        int pos;
        bit single;
        bit halt_seen;
        bit flush_pend;
        int sv;
        int cnt;
        bit smp;
    } mdl_t;

    cfg_t CA = '{period: 40, high: 2, stages: 5, maxs: 41};
    cfg_t CB = '{period: 4,  high: 1, stages: 3, maxs: 3};
    mdl_t ma, mb;

    function automatic mdl_t mnext(input mdl_t m, input cfg_t c, input bit r, input bit s,
                                   input bit ms, input bit sr, input bit hr, input bit rs,
                                   input bit fl);
        mdl_t n = m;
        bit   last = m.busy && (m.pos == c.period - 1);
        bit   fnow = m.flush_pend || fl;
        bit   hnow = m.halt_seen || hr;
        bit   lim  = (c.maxs != 0) && (m.cnt == c.maxs);
        bit   go   = 1'b0;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        n.smp        = m.busy && (m.pos == 0);
        n.flush_pend = last ? 1'b0 : fnow;
        n.halt_seen  = last ? 1'b0 : (m.halt_seen || (m.busy && hr));
        if (m.busy && !last) begin
            n.pos = m.pos + 1;
        end else if (last) begin
            n.busy = 1'b0;
            n.pos  = 0;
            if (fnow) n.sv = 0;
            if (lim)       n.st = 4;
            else if (hnow) n.st = 3;
            else if (m.single) n.st = 2;
            else go = 1'b1;
        end else begin
            case (m.st)
                0: if (s) begin
                    n.single = ms;
                    if (ms) n.st = 2; else go = 1'b1;
                end
                2: if (sr) go = 1'b1;
                3: if (rs) begin
                    if (m.single) n.st = 2; else go = 1'b1;
                end
                default: ;
            endcase
        end
        if (go) begin
            n.st   = 1;
            n.busy = 1'b1;
            n.pos  = 0;
            if (m.cnt < 65535) n.cnt = m.cnt + 1;
            if (!(last && fnow)) n.sv = ((m.sv << 1) | 1) & ((1 << c.stages) - 1);
        end
        return n;
    endfunction

    function automatic logic [63:0] mexp(input mdl_t m, input cfg_t c);
        logic [63:0] v = '0;
        v[30]    = m.busy && (m.pos == 0);
        v[29]    = m.busy && (m.pos < c.high);
        v[28]    = m.smp;
        v[27:20] = 8'(m.sv);
        v[19:4]  = 16'(m.cnt);
        v[3:1]   = 3'(m.st);
        v[0]     = (m.st == 4);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: advance both models on the edge, then compare every output.
    task automatic tick();
        logic [63:0] da, db;
        @(posedge clk);
        ma = mnext(ma, CA, rst, start, mode_step, step_req, halt_req, resume, flush);
        mb = mnext(mb, CB, rst, start, mode_step, step_req, halt_req, resume, flush);
        #1;
        da = {33'b0, cpu_en_a, phase_hi_a, sample_a, 3'b0, stage_valid_a,
              step_count_a, state_a, done_a};
        db = {33'b0, cpu_en_b, phase_hi_b, sample_b, 5'b0, stage_valid_b,
              step_count_b, state_b, done_b};
        chk("cycle_a", da, mexp(ma, CA));
        chk("cycle_b", db, mexp(mb, CB));
    endtask

    initial begin
        logic [13:0] en_b, smp_b;
        int          hi_cnt, acc;
        ma = '{default: 0};
        mb = '{default: 0};
        rst = 1'b1; start = 1'b0; mode_step = 1'b0; step_req = 1'b0;
        halt_req = 1'b0; resume = 1'b0; flush = 1'b0;
        repeat (3) tick();
        chk("rst_state_a", state_a, 0);
        chk("rst_count_a", step_count_a, 0);
        chk("rst_valid_a", stage_valid_a, 0);
        chk("rst_done_b",  done_b, 0);
        rst = 1'b0;
        tick();

        // Free run in both configurations from the same start.
        start = 1'b1; tick(); start = 1'b0;
        en_b = '0; smp_b = '0; hi_cnt = 0;
        for (int i = 1; i <= 80; i++) begin
            if (i <= 13) begin
                en_b[i]  = cpu_en_b;
                smp_b[i] = sample_b;
            end
            hi_cnt += int'(phase_hi_a);
            if (i == 1)  chk("valid_a_step1", stage_valid_a, 5'b00001);
            if (i == 41) chk("valid_a_step2", stage_valid_a, 5'b00011);
            if (i == 9)  chk("count_b_step3", step_count_b, 3);
            if (i == 13) begin
                chk("state_b_done", state_b, 4);
                chk("valid_b_done", stage_valid_b, 3'b111);
                chk("done_b", done_b, 1);
            end
            halt_req = (i == 51);
            tick();
        end
        halt_req = 1'b0;
        chk("en_b_pulses", en_b, 14'd546);
        chk("sample_b_pulses", smp_b, 14'd1092);
        chk("phase_hi_a_count", hi_cnt, 4);
        chk("halt_state_a", state_a, 3);
        chk("halt_count_a", step_count_a, 2);

        repeat (4) tick();
        resume = 1'b1; tick(); resume = 1'b0;
        chk("resume_en_a", cpu_en_a, 1);
        chk("resume_count_a", step_count_a, 3);

        repeat (44) tick();
        chk("valid_a_step4", stage_valid_a, 5'b01111);
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (35) tick();
        chk("flush_valid_a", stage_valid_a, 5'b00000);
        chk("flush_count_a", step_count_a, 5);
        repeat (40) tick();
        chk("after_flush_valid_a", stage_valid_a, 5'b00001);

        repeat (20) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midstep_rst_a", {cpu_en_a, phase_hi_a, sample_a, stage_valid_a,
                              step_count_a, state_a, done_a}, 0);

        // Single-step mode.
        start = 1'b1; mode_step = 1'b1; tick(); start = 1'b0; mode_step = 1'b0;
        chk("wait_state_a", state_a, 2);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            acc += int'(cpu_en_a | phase_hi_a);
            tick();
        end
        chk("wait_no_strobe", acc, 0);
        step_req = 1'b1; tick(); step_req = 1'b0;
        chk("single_en_a", cpu_en_a, 1);
        chk("single_count_a", step_count_a, 1);
        acc = 0;
        for (int i = 0; i < 45; i++) begin
            acc += int'(cpu_en_a);
            step_req = (i == 5);
            tick();
        end
        step_req = 1'b0;
        chk("single_one_pulse", acc, 1);
        chk("single_back_wait", state_a, 2);
        chk("single_count_hold", step_count_a, 1);

        // Randomized episodes; the first has no halts so run A reaches its limit.
        for (int ep = 0; ep < 5; ep++) begin
            rst = 1'b1; tick(); rst = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                start     = ($urandom % 16) == 0;
                mode_step = (ep != 0) && (($urandom % 3) == 0);
                step_req  = ($urandom % 8) == 0;
                halt_req  = (ep != 0) && (($urandom % 64) == 0);
                resume    = ($urandom % 24) == 0;
                flush     = ($urandom % 40) == 0;
                rst       = ($urandom % 3000) == 0;
                tick();
            end
            start = 1'b0; step_req = 1'b0; halt_req = 1'b0;
            resume = 1'b0; flush = 1'b0; rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
